// File: rtl/noc_link_pkg.sv
// Shared types and width helpers for the NoC link buffer.
// Default flit layout matches the router port: {is_tail, dest, data}.
package noc_link_pkg;

  localparam int FLIT_WIDTH_DEF         = 64;
  localparam int DEST_WIDTH_DEF         = 4;
  localparam int BUFFER_DEPTH_DEF       = 2;
  localparam int DOWNSTREAM_CREDITS_DEF = 2;

  typedef struct packed {
    logic                      is_tail;
    logic [DEST_WIDTH_DEF-1:0] dest;
    logic [FLIT_WIDTH_DEF-1:0] data;
  } flit_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index 0..depth-1, never less than one.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/noc_link_fifo.sv
// noc_link_fifo: synchronous FIFO, head read from registered pointer into storage.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: push on full is ignored unless a pop happens at the same edge.
module noc_link_fifo
  import noc_link_pkg::*;
#(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_dat,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_dat,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Modulo wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_dat  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/noc_credit_link_buffer.sv
// noc_credit_link_buffer: credit-based relay buffer on an inter-router link, registered outputs.
// Latency: 2 cycles send_in->send_out; 1 cycle on an empty FIFO when NOC_CREDIT_LINK_BYPASS_EN is defined.
// Backpressure: none on input (upstream holds BUFFER_DEPTH credits); output stalls at zero downstream credits.
module noc_credit_link_buffer
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH         = FLIT_WIDTH_DEF,
  parameter int DEST_WIDTH         = DEST_WIDTH_DEF,
  parameter int BUFFER_DEPTH       = BUFFER_DEPTH_DEF,
  parameter int DOWNSTREAM_CREDITS = DOWNSTREAM_CREDITS_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FLIT_WIDTH-1:0]              data_in,
  input  logic [DEST_WIDTH-1:0]              dest_in,
  input  logic                               is_tail_in,
  input  logic                               send_in,
  output logic                               credit_out,
  output logic [FLIT_WIDTH-1:0]              data_out,
  output logic [DEST_WIDTH-1:0]              dest_out,
  output logic                               is_tail_out,
  output logic                               send_out,
  input  logic                               credit_in,
  output logic [cnt_width(BUFFER_DEPTH)-1:0] occupancy,
  output logic                               err_overflow,
  output logic                               err_credit
);

  localparam int CRW = cnt_width(DOWNSTREAM_CREDITS);
  localparam logic [CRW-1:0] CR_MAX = CRW'(DOWNSTREAM_CREDITS);

  typedef struct packed {
    logic                  is_tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } link_flit_t;

  link_flit_t     w_in_flit;
  link_flit_t     w_head;
  link_flit_t     w_launch_flit;
  link_flit_t     r_flit;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic           w_has_credit;
  logic           w_bypass;
  logic           w_pop;
  logic           w_push;
  logic           w_launch;
  logic           w_overflow;
  logic           w_credit_err;
  logic [CRW-1:0] w_credit_nxt;
  logic [CRW-1:0] r_credits;
  logic           r_send_out;
  logic           r_credit_out;
  logic           r_err_ovf;
  logic           r_err_cr;

  assign w_in_flit = '{is_tail: is_tail_in, dest: dest_in, data: data_in};

  noc_link_fifo #(
    .WIDTH ($bits(link_flit_t)),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_dat (w_in_flit),
    .pop      (w_pop),
    .head_dat (w_head),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .count    (occupancy)
  );

  assign w_has_credit = (r_credits != '0);

`ifdef NOC_CREDIT_LINK_BYPASS_EN
  // Only legal when nothing is queued, so arrival order is kept.
  assign w_bypass = send_in && w_fifo_empty && w_has_credit;
`else
  assign w_bypass = 1'b0;
`endif

  // Pop decision uses pre-edge state, so a push into a full FIFO reuses the popped slot.
  assign w_pop         = !w_fifo_empty && w_has_credit;
  assign w_launch      = w_pop || w_bypass;
  assign w_push        = send_in && !w_bypass && (!w_fifo_full || w_pop);
  assign w_overflow    = send_in && !w_bypass && w_fifo_full && !w_pop;
  assign w_launch_flit = w_bypass ? w_in_flit : w_head;
  assign w_credit_err  = credit_in && (r_credits == CR_MAX);

  always_comb begin
    w_credit_nxt = r_credits;
    if (credit_in && !w_launch) begin
      if (r_credits != CR_MAX) begin
        w_credit_nxt = r_credits + CRW'(1);
      end
    end else if (!credit_in && w_launch) begin
      w_credit_nxt = r_credits - CRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits    <= CR_MAX;
      r_send_out   <= 1'b0;
      r_credit_out <= 1'b0;
      r_flit       <= '0;
      r_err_ovf    <= 1'b0;
      r_err_cr     <= 1'b0;
    end else begin
      r_credits    <= w_credit_nxt;
      r_send_out   <= w_launch;
      r_credit_out <= w_launch;
      if (w_launch) begin
        r_flit <= w_launch_flit;
      end
      if (w_overflow) begin
        r_err_ovf <= 1'b1;
      end
      if (w_credit_err) begin
        r_err_cr <= 1'b1;
      end
    end
  end

  assign send_out     = r_send_out;
  assign credit_out   = r_credit_out;
  assign data_out     = r_flit.data;
  assign dest_out     = r_flit.dest;
  assign is_tail_out  = r_flit.is_tail;
  assign err_overflow = r_err_ovf;
  assign err_credit   = r_err_cr;

endmodule

// File: tb/tb_noc_credit_link_buffer.sv
// Directed bench for noc_credit_link_buffer with an in-order flit scoreboard.
// Build with NOC_CREDIT_LINK_BYPASS_EN defined to exercise the 1-cycle bypass path.
module tb_noc_credit_link_buffer;
  import noc_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_in;
  logic [3:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        credit_out;
  logic [63:0] data_out;
  logic [3:0]  dest_out;
  logic        is_tail_out;
  logic        send_out;
  logic        credit_in;
  logic [1:0]  occupancy;
  logic        err_overflow;
  logic        err_credit;

  logic        credit_man  = 1'b0;
  logic        credit_auto = 1'b0;
  logic        auto_en     = 1'b0;
  logic [2:0]  hist        = '0;
  int          tests       = 0;
  int          fails       = 0;
  int          max_occ     = 0;
  flit_t       sb[$];
  flit_t       mon_exp;

  always #5 clk = ~clk;

  assign credit_in = credit_man | credit_auto;

  noc_credit_link_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .is_tail_out  (is_tail_out),
    .send_out     (send_out),
    .credit_in    (credit_in),
    .occupancy    (occupancy),
    .err_overflow (err_overflow),
    .err_credit   (err_credit)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] de, input logic t);
    send_in    = v;
    data_in    = d;
    dest_in    = de;
    is_tail_in = t;
  endtask

  task automatic send_exp(input logic [63:0] d, input logic [3:0] de, input logic t);
    flit_t f;
    drive(1'b1, d, de, t);
    f.is_tail = t;
    f.dest    = de;
    f.data    = d;
    sb.push_back(f);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_send"}, send_out, 1'b0);
    chk({tag, "_credit"}, credit_out, 1'b0);
    chk({tag, "_data"}, data_out, 64'h0);
    chk({tag, "_dest"}, dest_out, 4'h0);
    chk({tag, "_tail"}, is_tail_out, 1'b0);
    chk({tag, "_occ"}, occupancy, 2'd0);
    chk({tag, "_eovf"}, err_overflow, 1'b0);
    chk({tag, "_ecr"}, err_credit, 1'b0);
  endtask

  // Output monitor: every delivered flit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      hist = '0;
    end else begin
      hist = {hist[1:0], send_out};
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (send_out) begin
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL sb_extra: observed flit %0h expected no flit", data_out);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          tests++;
          assert ({is_tail_out, dest_out, data_out} === mon_exp) else begin
            fails++;
            $error("FAIL sb_order: observed %0h expected %0h",
                   {is_tail_out, dest_out, data_out}, mon_exp);
          end
        end
      end
    end
  end

  // Downstream model: returns a credit three cycles after each send_out.
  always @(posedge clk) begin
    #1;
    credit_auto = auto_en & hist[2];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single flit, latency and credit return.
    send_exp(64'hA5A5, 4'h3, 1'b1);
    tick();
    drive(1'b0, 64'h0, 4'h0, 1'b0);
`ifdef NOC_CREDIT_LINK_BYPASS_EN
    chk("t1_send_t1", send_out, 1'b1);
    chk("t1_credit_t1", credit_out, 1'b1);
    chk("t1_data", data_out, 64'hA5A5);
    chk("t1_occ_bypass", occupancy, 2'd0);
    tick();
    chk("t1_send_t2", send_out, 1'b0);
`else
    chk("t1_send_t1", send_out, 1'b0);
    chk("t1_occ_t1", occupancy, 2'd1);
    tick();
    chk("t1_send_t2", send_out, 1'b1);
    chk("t1_credit_t2", credit_out, 1'b1);
    chk("t1_data", data_out, 64'hA5A5);
    chk("t1_dest", dest_out, 4'h3);
    chk("t1_tail", is_tail_out, 1'b1);
    chk("t1_occ_t2", occupancy, 2'd0);
    tick();
    chk("t1_send_t3", send_out, 1'b0);
    chk("t1_credit_t3", credit_out, 1'b0);
    chk("t1_data_hold", data_out, 64'hA5A5);
`endif
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    chk("t1_credit_ret_ok", err_credit, 1'b0);
    chk("t1_sb_empty", sb.size(), 0);
    tick();

    // Back-to-back burst with delayed credit return.
    max_occ = 0;
    auto_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_exp(64'h1000 + 64'(i), 4'(i), i == 3);
      tick();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    wait_drain("burst_drain", 40);
    repeat (6) tick();
    auto_en = 1'b0;
    chk("burst_max_occ", max_occ <= 2, 1'b1);
    chk("burst_eovf", err_overflow, 1'b0);
    chk("burst_ecr", err_credit, 1'b0);

    // No credits returned: two delivered, two buffered, fifth dropped.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) send_exp(64'h3000 + 64'(i), 4'h5, 1'b0);
      else       drive(1'b1, 64'hDEAD, 4'hF, 1'b1);
      tick();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    repeat (3) tick();
    chk("ovf_occ", occupancy, 2'd2);
    chk("ovf_flag", err_overflow, 1'b1);
    chk("ovf_delivered", sb.size(), 2);
    credit_man = 1'b1;
    tick();
    tick();
    credit_man = 1'b0;
    wait_drain("ovf_drain", 10);
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    repeat (4) tick();
    chk("ovf_dropped_occ", occupancy, 2'd0);
    chk("ovf_sticky", err_overflow, 1'b1);

    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    chk("rst1_eovf", err_overflow, 1'b0);

    // Full FIFO, then push + pop + credit_in at the same edge.
    for (int i = 0; i < 4; i++) begin
      send_exp(64'h4000 + 64'(i), 4'h6, i == 3);
      tick();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    chk("t4_full", occupancy, 2'd2);
    credit_man = 1'b1;
    tick();
    send_exp(64'h4004, 4'h6, 1'b0);
    tick();
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    credit_man = 1'b0;
    chk("t4_occ_same", occupancy, 2'd2);
    chk("t4_no_ovf", err_overflow, 1'b0);
    chk("t4_no_ecr", err_credit, 1'b0);
    chk("t4_pop_send", send_out, 1'b1);
    chk("t4_pop_data", data_out, 64'h4002);
    tick();
    chk("t4_next_send", send_out, 1'b1);
    chk("t4_next_data", data_out, 64'h4003);
    chk("t4_next_occ", occupancy, 2'd1);
    tick();
    chk("t4_cnt_unchanged", send_out, 1'b0);
    chk("t4_hold_occ", occupancy, 2'd1);

    // Refill credits to max, then one extra credit.
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    wait_drain("t5_drain", 10);
    credit_man = 1'b1;
    tick();
    tick();
    credit_man = 1'b0;
    tick();
    chk("t5_no_err", err_credit, 1'b0);
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    chk("t5_err_credit", err_credit, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      send_exp(64'h5000 + 64'(i), 4'h9, i == 2);
      tick();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    repeat (5) tick();
    chk("t5_cnt_sat_occ", occupancy, 2'd1);
    chk("t5_cnt_sat_sb", sb.size(), 1);

    // Asynchronous reset while a flit is on the output.
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    tick();
    drive(1'b1, 64'h7777, 4'h7, 1'b1);
    chk("pre_rst_send", send_out, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    sb.delete();
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Post-reset credit counter must be back at its full value.
    for (int i = 0; i < 3; i++) begin
      send_exp(64'h6000 + 64'(i), 4'hA, i == 2);
      tick();
    end
    drive(1'b0, 64'h0, 4'h0, 1'b0);
    repeat (5) tick();
    chk("post_rst_occ", occupancy, 2'd1);
    chk("post_rst_sb", sb.size(), 1);
    chk("post_rst_ecr", err_credit, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
